// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph loader.
//   GLYPH_HDR  : byte value that opens a glyph packet
//   GLYPH_ROWS : rows per glyph (one byte per row)
//   ROW_W      : width of a row index
//   ADDR_W     : glyph memory address width, {ascii[7:0], row[3:0]}
package glyph_pkg;

  localparam logic [7:0] GLYPH_HDR  = 8'h47;
  localparam int         GLYPH_ROWS = 16;
  localparam int         ROW_W      = 4;
  localparam int         ADDR_W     = 12;

  // state   | meaning
  // IDLE    | hunting for the header byte, non-header bytes dropped
  // CODE    | next byte is the ascii code
  // ROWS    | collecting row bytes into the row buffer
  // CSUM    | next byte is the checksum
  // COMMIT  | streaming buffered rows to glyph memory, input stalled
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CODE   = 3'd1,
    ST_ROWS   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_COMMIT = 3'd4
  } glyph_state_e;

  function automatic logic [ADDR_W-1:0] glyph_addr(input logic [7:0] ascii,
                                                   input logic [ROW_W-1:0] row);
    return {ascii, row};
  endfunction

endpackage

// File: rtl/glyph_row_buf.sv
// 16x8 row buffer: one synchronous write port, one combinational read port.
//   clk     : clock
//   wr_en   : write strobe
//   wr_row  : row index written
//   wr_data : row bitmap written
//   rd_row  : row index read
//   rd_data : row bitmap at rd_row
// Contents are not reset; a packet is only committed after all rows have
// been rewritten, so stale data is never observable.
module glyph_row_buf
  import glyph_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [7:0]       wr_data,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [GLYPH_ROWS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  assign rd_data = mem[rd_row];

endmodule

// File: rtl/glyph_loader.sv
// Glyph packet loader: receives HDR, ascii, ROWS row bytes and an XOR
// checksum, buffers the rows, and only after the checksum matches writes
// them to glyph memory one row per cycle.
//   clk      : clock
//   resetn   : asynchronous active-low reset
//   in_data  : incoming packet byte
//   in_valid : in_data valid
//   in_ready : byte accepted when in_valid && in_ready
//   wr_addr  : glyph memory address {ascii, row}
//   wr_data  : row bitmap, bit n = pixel column n
//   wr_en    : glyph memory write strobe
//   done     : one-cycle pulse after a commit
//   err      : one-cycle pulse on checksum mismatch
//   busy     : high outside IDLE
//
// state   | meaning
// IDLE    | waiting for HDR, other bytes discarded
// CODE    | capture ascii code, seed running XOR
// ROWS    | buffer row bytes, accumulate XOR
// CSUM    | compare checksum byte against running XOR
// COMMIT  | write rows 1..15 (row 0 is issued on checksum acceptance)
module glyph_loader
  import glyph_pkg::*;
#(
  parameter logic [7:0] HDR  = GLYPH_HDR,
  parameter int         ROWS = GLYPH_ROWS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ONE_ROW  = ROW_W'(1);

  glyph_state_e      state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        ascii_q, ascii_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              wr_en_d, done_d, err_d;

  logic              accept;
  logic              buf_we;
  logic [ROW_W-1:0]  buf_rd_row;
  logic [7:0]        buf_rd_data;
  logic [ROW_W-1:0]  row_next;

  assign in_ready = (state_q != ST_COMMIT);
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign row_next = row_q + ONE_ROW;

  // Outputs are registered, so the row being presented next cycle must be
  // read one step ahead: row 0 while in CSUM, row_q+1 while in COMMIT.
  assign buf_rd_row = (state_q == ST_COMMIT) ? row_next : row_q;

  glyph_row_buf u_row_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_row  (row_q),
    .wr_data (in_data),
    .rd_row  (buf_rd_row),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_q   <= '0;
      csum_q  <= '0;
      ascii_q <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      row_q   <= row_d;
      csum_q  <= csum_d;
      ascii_q <= ascii_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      wr_en   <= wr_en_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    csum_d    = csum_q;
    ascii_d   = ascii_q;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    buf_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && (in_data == HDR)) begin
          state_d = ST_CODE;
          row_d   = '0;
          csum_d  = '0;
        end
      end

      ST_CODE: begin
        if (accept) begin
          ascii_d = in_data;
          csum_d  = in_data;
          state_d = ST_ROWS;
        end
      end

      ST_ROWS: begin
        if (accept) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ in_data;
          row_d  = row_next;
          if (row_q == LAST_ROW) begin
            state_d = ST_CSUM;
            row_d   = '0;
          end
        end
      end

      ST_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d   = ST_COMMIT;
            wr_en_d   = 1'b1;
            wr_addr_d = glyph_addr(ascii_q, row_q);
            wr_data_d = buf_rd_data;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end

      ST_COMMIT: begin
        if (row_q == LAST_ROW) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          row_d   = '0;
        end else begin
          row_d     = row_next;
          wr_en_d   = 1'b1;
          wr_addr_d = glyph_addr(ascii_q, row_next);
          wr_data_d = buf_rd_data;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
